// File: rtl/time_mux_rr.sv
// time_mux_rr: N-channel time-division multiplexer.
//
// In auto mode the block rotates through the enabled channels and spends a
// programmable number of cycles on each one. In manual mode it follows an
// external channel select. The word, the channel index and valid are
// registered together, so they are mutually aligned and lag cur_ch by one
// cycle.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_en        run enable; low returns the block to idle
//   i_mode      0 = auto round-robin, 1 = manual select
//   i_man_sel   channel select used in manual mode (clamped to N_CH-1)
//   i_ch_en     per-channel enable mask
//   i_slot_len  cycles per slot in auto mode (0 behaves as 1)
//   i_data_in   packed channel words, channel i at [i*DW +: DW]
//   o_data_out  registered selected word
//   o_ch_out    channel index of o_data_out
//   o_valid     o_data_out comes from an enabled channel while running
//   o_slot_tick one-cycle pulse at each auto-mode slot end
module time_mux_rr #(
  parameter int unsigned DW     = 16,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned SLOT_W = 16,
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_mode,
  input  logic [CH_W-1:0]    i_man_sel,
  input  logic [N_CH-1:0]    i_ch_en,
  input  logic [SLOT_W-1:0]  i_slot_len,
  input  logic [N_CH*DW-1:0] i_data_in,
  output logic [DW-1:0]      o_data_out,
  output logic [CH_W-1:0]    o_ch_out,
  output logic               o_valid,
  output logic               o_slot_tick
);

  localparam logic [CH_W-1:0] MaxCh = CH_W'(N_CH - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e             r_state;
  logic [CH_W-1:0]    r_cur_ch;
  logic [SLOT_W-1:0]  r_slot_cnt;
  logic [DW-1:0]      r_data_out;
  logic [CH_W-1:0]    r_ch_out;
  logic               r_valid;
  logic               r_slot_tick;

  logic [DW-1:0]      w_sel_data;
  logic               w_cur_en;
  logic [CH_W-1:0]    w_low_ch;
  logic [CH_W-1:0]    w_next_ch;
  logic [CH_W-1:0]    w_man_ch;
  logic [SLOT_W-1:0]  w_len_m1;
  logic               w_slot_end;

  // Word and enable bit of the channel currently selected.
  always_comb begin
    w_sel_data = '0;
    w_cur_en   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_cur_ch == CH_W'(i)) begin
        w_sel_data = i_data_in[i*DW +: DW];
        w_cur_en   = i_ch_en[i];
      end
    end
  end

  // Lowest enabled channel, 0 when the mask is empty.
  always_comb begin
    w_low_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_ch_en[i]) begin
        w_low_ch = CH_W'(i);
      end
    end
  end

  // Next enabled channel searching upward from cur_ch+1 with wrap. The last
  // candidate visited is cur_ch itself, so a lone enabled channel stays put;
  // an empty mask holds cur_ch.
  always_comb begin
    logic [CH_W-1:0] idx;
    logic            found;
    w_next_ch = r_cur_ch;
    idx       = r_cur_ch;
    found     = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (idx == MaxCh) begin
        idx = '0;
      end else begin
        idx = idx + 1'b1;
      end
      if (!found && i_ch_en[idx]) begin
        w_next_ch = idx;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    w_man_ch = (i_man_sel > MaxCh) ? MaxCh : i_man_sel;
  end

  // A slot length of 0 behaves as 1. The compare is >= so that shrinking
  // slot_len below the current count ends the slot immediately.
  always_comb begin
    w_len_m1   = (i_slot_len == '0) ? '0 : i_slot_len - 1'b1;
    w_slot_end = (r_slot_cnt >= w_len_m1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_cur_ch    <= '0;
      r_slot_cnt  <= '0;
      r_data_out  <= '0;
      r_ch_out    <= '0;
      r_valid     <= 1'b0;
      r_slot_tick <= 1'b0;
    end else begin
      // Output pipeline runs in every state; only valid depends on state.
      r_data_out  <= w_sel_data;
      r_ch_out    <= r_cur_ch;
      r_valid     <= (r_state == StRun) && w_cur_en;
      r_slot_tick <= 1'b0;

      unique case (r_state)
        StIdle: begin
          if (i_en) begin
            r_state    <= StRun;
            r_cur_ch   <= w_low_ch;
            r_slot_cnt <= '0;
          end
        end
        StRun: begin
          if (!i_en) begin
            // Disable wins over a coincident slot end: no tick, no advance.
            r_state    <= StIdle;
            r_slot_cnt <= '0;
          end else if (i_mode) begin
            // Holding the count at 0 gives a full slot on return to auto.
            r_cur_ch   <= w_man_ch;
            r_slot_cnt <= '0;
          end else if (w_slot_end) begin
            r_slot_cnt  <= '0;
            r_slot_tick <= 1'b1;
            r_cur_ch    <= w_next_ch;
          end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_data_out  = r_data_out;
  assign o_ch_out    = r_ch_out;
  assign o_valid     = r_valid;
  assign o_slot_tick = r_slot_tick;

endmodule

// File: tb/tb_time_mux_rr.sv
// Testbench for time_mux_rr: directed stimulus with hand-computed expected
// outputs pushed into a scoreboard queue; a monitor pops one entry after
// every rising edge and compares it with the DUT outputs.
module tb_time_mux_rr;

  localparam int DW = 16;
  localparam int NCH = 4;
  localparam int SW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    ch;
    logic          valid;
    logic          tick;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           en;
  logic           mode;
  logic [1:0]     man_sel;
  logic [NCH-1:0] ch_en;
  logic [SW-1:0]  slot_len;
  logic [NCH*DW-1:0] data_in;
  logic [DW-1:0]  data_out;
  logic [1:0]     ch_out;
  logic           valid;
  logic           slot_tick;

  logic [DW-1:0] words [NCH];
  exp_t          sb_q [$];
  int            n_checks;
  int            n_fail;

  time_mux_rr #(
    .DW     (DW),
    .N_CH   (NCH),
    .SLOT_W (SW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_mode      (mode),
    .i_man_sel   (man_sel),
    .i_ch_en     (ch_en),
    .i_slot_len  (slot_len),
    .i_data_in   (data_in),
    .o_data_out  (data_out),
    .o_ch_out    (ch_out),
    .o_valid     (valid),
    .o_slot_tick (slot_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Push the expected output for the coming edge, then move to the next
  // falling edge where the caller may change inputs.
  task automatic step(input int ch, input bit v, input bit t);
    exp_t e;
    e.data  = words[ch];
    e.ch    = 2'(ch);
    e.valid = v;
    e.tick  = t;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one scoreboard entry is consumed per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("data_out", 32'(data_out), 32'(e.data));
        check("ch_out", 32'(ch_out), 32'(e.ch));
        check("valid", 32'(valid), 32'(e.valid));
        check("slot_tick", 32'(slot_tick), 32'(e.tick));
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    words[0] = 16'h1111;
    words[1] = 16'h2222;
    words[2] = 16'h3333;
    words[3] = 16'h4444;
    data_in  = {words[3], words[2], words[1], words[0]};
    en       = 1'b0;
    mode     = 1'b0;
    man_sel  = 2'd0;
    ch_en    = 4'b1111;
    slot_len = 16'd3;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_ch", 32'(ch_out), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_tick", 32'(slot_tick), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: valid stays low.
    step(0, 0, 0);
    step(0, 0, 0);

    // Auto rotation, all channels, slot length 3.
    en = 1'b1;
    step(0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 3; j++) begin
        step(c, 1, j == 2);
      end
    end
    step(0, 1, 0);

    // Skip disabled channels, slot length 2.
    ch_en    = 4'b1010;
    slot_len = 16'd2;
    step(0, 0, 1);
    step(1, 1, 0);
    step(1, 1, 1);
    step(3, 1, 0);
    step(3, 1, 1);
    step(1, 1, 0);
    step(1, 1, 1);

    // Empty mask: channel held, valid low, tick keeps pulsing.
    ch_en = 4'b0000;
    step(3, 0, 0);
    step(3, 0, 1);
    step(3, 0, 0);
    step(3, 0, 1);

    // Slot length 1 and 0: advance and tick every cycle.
    ch_en    = 4'b1111;
    slot_len = 16'd1;
    step(3, 1, 1);
    step(0, 1, 1);
    slot_len = 16'd0;
    step(1, 1, 1);
    step(2, 1, 1);
    step(3, 1, 1);

    // Shrink slot length from 10 to 2 with the count at 5.
    slot_len = 16'd10;
    for (int j = 0; j < 5; j++) begin
      step(0, 1, 0);
    end
    slot_len = 16'd2;
    step(0, 1, 1);
    step(1, 1, 0);

    // Manual mode; the pending slot end is dropped.
    mode    = 1'b1;
    man_sel = 2'd2;
    step(1, 1, 0);
    step(2, 1, 0);
    man_sel = 2'd3;
    ch_en   = 4'b0111;
    step(2, 1, 0);
    step(3, 0, 0);
    step(3, 0, 0);

    // Back to auto: full slot on channel 3, then wrap to channel 0.
    mode  = 1'b0;
    ch_en = 4'b1011;
    step(3, 1, 0);
    step(3, 1, 1);
    step(0, 1, 0);
    step(0, 1, 1);
    step(1, 1, 0);

    // en falls on the slot-end cycle: no tick, channel held.
    en = 1'b0;
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);

    // en rises with a single enabled channel.
    en    = 1'b1;
    ch_en = 4'b0100;
    step(1, 0, 0);
    step(2, 1, 0);
    step(2, 1, 1);
    step(2, 1, 0);

    // Asynchronous reset mid-slot, away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("arst_data", 32'(data_out), 32'h0);
    check("arst_ch", 32'(ch_out), 32'h0);
    check("arst_valid", 32'(valid), 32'h0);
    check("arst_tick", 32'(slot_tick), 32'h0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);

    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_mux_rr.md
Name: time_mux_rr

Overview:
- Parametrised N-channel time-division multiplexer, successor to the 2:1 timer selector in the UART/timer datapath.
- Auto mode: rotates through the enabled input channels, one channel per programmable slot length (in clock cycles).
- Manual mode: follows an external channel select.
- Output data, channel index and valid are registered and mutually aligned; a one-cycle tick marks every slot boundary.

Parameters:
- DW, 16, width of each channel word.
- N_CH, 4, number of input channels (>=1).
- SLOT_W, 16, width of slot-length and slot counter.
- CH_W, $clog2(N_CH) (min 1), width of channel index (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  run enable; 0 forces IDLE.
- mode  in  1  0 = auto round-robin, 1 = manual.
- man_sel  in  CH_W  channel select used in manual mode.
- ch_en  in  N_CH  per-channel enable mask; bit i enables channel i.
- slot_len  in  SLOT_W  cycles per slot in auto mode; 0 treated as 1.
- data_in  in  N_CH*DW  packed channel words; channel i occupies bits [i*DW +: DW].
- data_out  out  DW  registered selected word.
- ch_out  out  CH_W  index of channel currently on data_out.
- valid  out  1  data_out is from an enabled channel while running.
- slot_tick  out  1  one-cycle pulse at each auto-mode slot end.

Behaviour:
- Reset (rst=0, async): state=IDLE, cur_ch=0, slot_cnt=0, data_out=0, ch_out=0, valid=0, slot_tick=0.
- States: IDLE, RUN.
  - IDLE -> RUN when en=1. Entry action: cur_ch = lowest enabled channel (0 if mask empty), slot_cnt=0.
  - RUN -> IDLE when en=0. slot_cnt cleared; cur_ch held; valid=0 from the next cycle.
- Output pipeline, one cycle latency, every cycle:
  - data_out <= data_in[cur_ch].
  - ch_out <= cur_ch.
  - valid <= (state==RUN) & ch_en[cur_ch].
  - data_out/ch_out also update in IDLE; only valid is forced 0.
- Auto mode (RUN, mode=0):
  - slot_cnt increments each cycle.
  - When slot_cnt == max(slot_len,1)-1: slot_cnt <= 0, slot_tick <= 1 for one cycle, cur_ch <= next enabled channel.
  - Next-channel search order: cur_ch+1 upward, wrapping N_CH-1 -> 0. Disabled channels are skipped.
  - If cur_ch is the only enabled channel, it stays and the tick still pulses.
  - Empty mask: cur_ch held, valid=0, tick still pulses.
- slot_len change mid-slot takes effect at the next comparison. If slot_cnt already exceeds the new length-1, the slot ends on that cycle; the compare is >=.
- ch_en change mid-slot: current slot completes on cur_ch; valid follows ch_en[cur_ch] each cycle.
- Manual mode (RUN, mode=1):
  - cur_ch <= man_sel every cycle; slot_cnt held at 0; slot_tick=0.
  - man_sel >= N_CH is clamped to N_CH-1.
  - Disabled channel gives valid=0.
- Mode 1 -> 0: slot_cnt=0; rotation continues from the current cur_ch, which receives a full slot.
- Mode 0 -> 1: takes effect next cycle; any pending tick is dropped.
- Simultaneous en fall and slot end: en wins; no tick, no channel advance.
- N_CH=1: cur_ch always 0; tick behaves as above.
- Async reset mid-slot: all outputs to reset values immediately, independent of clk.

Test Plan:
- Reset/IDLE: rst=0 during RUN -> data_out=0, ch_out=0, valid=0, slot_tick=0 without waiting for clk. After release with en=0 -> valid stays 0.
- Auto rotation: N_CH=4, ch_en=4'b1111, slot_len=3, data_in words 0x1111/0x2222/0x3333/0x4444, en=1.
  - ch_out sequence 0,0,0,1,1,1,2,2,2,3,3,3,0...
  - data_out matches ch_out; valid=1.
  - slot_tick pulses every 3rd cycle.
- Skip and empty mask: ch_en=4'b1010, slot_len=2 -> ch_out alternates 1,1,3,3,1... Then ch_en=0 -> ch_out holds, valid=0, tick continues every 2 cycles.
- slot_len=0 and 1: both give a channel change and tick every cycle. Changing slot_len from 10 to 2 at slot_cnt=5 ends the slot next cycle.
- Manual mode: mode=1, man_sel=2 -> ch_out=2, data_out=0x3333 one cycle later, no ticks. man_sel=3 with ch_en[3]=0 -> valid=0. Return to mode=0 -> full slot on channel 3, then advance to the next enabled channel.
- Enable edges: en falls on the slot-end cycle -> no tick, cur_ch unchanged, valid=0 next cycle. en rises with ch_en=4'b0100 -> ch_out=2, valid=1 one cycle later.
